// File: rtl/pattern_scan.sv
// ---------------------------------------------------------------------------
// pattern_scan
//
// Scanning-bar test pattern generator for the LED panel row driver. Each
// clock it emits one registered top/bottom half-row of RGB data together
// with the row address the data belongs to. A bar of BAR_W pixels sweeps
// across the panel, either vertically (a horizontal bar moving through the
// rows) or horizontally (a vertical bar moving through the columns). It
// either bounces between the two edges or wraps back to the start. The bar
// position only moves on the last row of a frame, so a frame is never drawn
// with two different positions.
//
// Ports
//   clk_in           system clock
//   reset_in         synchronous, active-high reset
//   enable_in        1 = step timer runs; 0 = timer and pending steps
//                    frozen while the display keeps scanning
//   mode_in[1:0]     bit0 axis (0 vertical, 1 horizontal),
//                    bit1 motion (0 bounce, 1 wrap)
//   colour_in[2:0]   bit0 red, bit1 green, bit2 blue for every lit pixel
//   top_out          top-half row data, packed {blue, green, red};
//                    bit c of each plane is column c
//   bot_out          bottom-half row data, same packing
//   row_address_out  row address that top_out/bot_out belong to
//   frame_start_out  high while row_address_out == 0
//   pos_out          bar position currently being displayed
// ---------------------------------------------------------------------------
module pattern_scan #(
    parameter int EFFECT_TIMER = 100_000,
    parameter int NUM_ROWS     = 32,
    parameter int NUM_COLS     = 64,
    parameter int BAR_W        = 1,
    localparam int HALF        = NUM_ROWS / 2,
    localparam int ADDR_W      = $clog2(HALF),
    localparam int POS_W       = $clog2(((NUM_ROWS > NUM_COLS) ? NUM_ROWS : NUM_COLS) + 1)
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  enable_in,
    input  logic [1:0]            mode_in,
    input  logic [2:0]            colour_in,
    output logic [3*NUM_COLS-1:0] top_out,
    output logic [3*NUM_COLS-1:0] bot_out,
    output logic [ADDR_W-1:0]     row_address_out,
    output logic                  frame_start_out,
    output logic [POS_W-1:0]      pos_out
);

    // -----------------------------------------------------------------------
    // Derived constants
    // -----------------------------------------------------------------------
    // A timer of width 0 is not legal, so EFFECT_TIMER == 0 still gets 1 bit.
    localparam int TMR_W = (EFFECT_TIMER > 0) ? $clog2(EFFECT_TIMER + 1) : 1;

    // One extra bit so pos + BAR_W and counter + HALF can never overflow.
    localparam int EXT_W = POS_W + 1;

    localparam logic [TMR_W-1:0]  TIMER_LAST = TMR_W'(EFFECT_TIMER);
    localparam logic [ADDR_W-1:0] ROW_LAST   = ADDR_W'(HALF - 1);
    localparam logic [POS_W-1:0]  PMAX_VERT  = POS_W'(NUM_ROWS - BAR_W);
    localparam logic [POS_W-1:0]  PMAX_HORZ  = POS_W'(NUM_COLS - BAR_W);
    localparam logic [EXT_W-1:0]  BAR_EXT    = EXT_W'(BAR_W);
    localparam logic [EXT_W-1:0]  HALF_EXT   = EXT_W'(HALF);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [TMR_W-1:0]  timer;
    logic [ADDR_W-1:0] counter;
    logic              pending;
    logic [POS_W-1:0]  pos;
    dir_e              dir;
    logic              axis_q;     // axis bit of mode_in from the previous edge

    // -----------------------------------------------------------------------
    // Control decode
    // -----------------------------------------------------------------------
    logic             axis;
    logic             wrap;
    logic             axis_change;
    logic             step_event;
    logic             frame_last;
    logic             apply_step;
    logic [POS_W-1:0] pmax;

    assign axis        = mode_in[0];
    assign wrap        = mode_in[1];
    assign axis_change = (axis_q != axis);
    assign step_event  = enable_in && (timer == TIMER_LAST);
    assign frame_last  = (counter == ROW_LAST);
    assign pmax        = axis ? PMAX_HORZ : PMAX_VERT;

    // A step that lands on the last row is applied straight away; otherwise
    // it waits in pending. A held-off step stays frozen while disabled.
    assign apply_step  = frame_last && (step_event || (pending && enable_in));

    // -----------------------------------------------------------------------
    // Next position / direction for one applied step
    // -----------------------------------------------------------------------
    logic [POS_W-1:0] pos_step;
    dir_e             dir_step;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the if/else tree can leave it unassigned and
        // infer a latch.
        pos_step = pos;
        dir_step = dir;

        if (pmax == '0) begin
            // Bar fills the whole extent: nothing to move.
            pos_step = '0;
            dir_step = DIR_UP;
        end else if (wrap) begin
            dir_step = DIR_UP;
            pos_step = (pos >= pmax) ? '0 : pos + 1'b1;
        end else if (dir == DIR_UP) begin
            if (pos < pmax) begin
                pos_step = pos + 1'b1;
            end else begin
                // Turn at the far edge without dwelling on it.
                dir_step = DIR_DOWN;
                pos_step = pos - 1'b1;
            end
        end else begin
            if (pos > '0) begin
                pos_step = pos - 1'b1;
            end else begin
                dir_step = DIR_UP;
                pos_step = pos + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Lit-pixel masks for the row currently addressed by counter
    // -----------------------------------------------------------------------
    logic [EXT_W-1:0]    pos_ext;
    logic [EXT_W-1:0]    bar_end;
    logic [EXT_W-1:0]    top_row;
    logic [EXT_W-1:0]    bot_row;
    logic                top_row_lit;
    logic                bot_row_lit;
    logic [NUM_COLS-1:0] col_mask;
    logic [NUM_COLS-1:0] top_mask;
    logic [NUM_COLS-1:0] bot_mask;

    assign pos_ext     = EXT_W'(pos);
    assign bar_end     = pos_ext + BAR_EXT;
    assign top_row     = EXT_W'(counter);
    assign bot_row     = top_row + HALF_EXT;
    assign top_row_lit = (top_row >= pos_ext) && (top_row < bar_end);
    assign bot_row_lit = (bot_row >= pos_ext) && (bot_row < bar_end);

    always_comb begin
        col_mask = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            col_mask[c] = (EXT_W'(c) >= pos_ext) && (EXT_W'(c) < bar_end);
        end
    end

    // Vertical sweep lights whole rows; horizontal sweep lights the same
    // columns on every row of both halves.
    assign top_mask = axis ? col_mask : {NUM_COLS{top_row_lit}};
    assign bot_mask = axis ? col_mask : {NUM_COLS{bot_row_lit}};

    logic [3*NUM_COLS-1:0] top_pix;
    logic [3*NUM_COLS-1:0] bot_pix;

    assign top_pix = {top_mask & {NUM_COLS{colour_in[2]}},
                      top_mask & {NUM_COLS{colour_in[1]}},
                      top_mask & {NUM_COLS{colour_in[0]}}};
    assign bot_pix = {bot_mask & {NUM_COLS{colour_in[2]}},
                      bot_mask & {NUM_COLS{colour_in[1]}},
                      bot_mask & {NUM_COLS{colour_in[0]}}};

    // -----------------------------------------------------------------------
    // Sequential state and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        //
        // NOTE: axis_q tracks mode_in even during reset, so leaving reset
        // with a horizontal mode does not look like an axis change.
        axis_q <= axis;

        if (reset_in) begin
            timer           <= '0;
            counter         <= '0;
            pending         <= 1'b0;
            pos             <= '0;
            dir             <= DIR_UP;
            top_out         <= '0;
            bot_out         <= '0;
            row_address_out <= '0;
            frame_start_out <= 1'b0;
        end else begin
            // Display scan never stops, whatever enable_in says.
            counter         <= frame_last ? '0 : counter + 1'b1;
            row_address_out <= counter;
            frame_start_out <= (counter == '0);
            top_out         <= top_pix;
            bot_out         <= bot_pix;

            if (axis_change) begin
                // Restart the sweep on the new axis; any step on this edge
                // is discarded.
                timer   <= '0;
                pending <= 1'b0;
                pos     <= '0;
                dir     <= DIR_UP;
            end else begin
                if (enable_in) begin
                    timer <= (timer == TIMER_LAST) ? '0 : timer + 1'b1;
                end

                if (apply_step) begin
                    pos     <= pos_step;
                    dir     <= dir_step;
                    pending <= 1'b0;
                end else if (step_event) begin
                    // Several steps inside one frame collapse into this flag.
                    pending <= 1'b1;
                end
            end
        end
    end

    assign pos_out = pos;

endmodule

// File: tb/tb_pattern_scan.sv
// ---------------------------------------------------------------------------
// tb_pattern_scan
//
// Directed bench for pattern_scan with NUM_ROWS=8, NUM_COLS=8, BAR_W=2,
// EFFECT_TIMER=3 and red colour. The stimulus process schedules input
// changes by edge number and pushes hand-computed expectations (edge,
// output field, value) into a scoreboard. A monitor on the falling edge
// compares every expectation due on that edge against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pattern_scan;

    localparam int NUM_ROWS     = 8;
    localparam int NUM_COLS     = 8;
    localparam int BAR_W        = 2;
    localparam int EFFECT_TIMER = 3;

    logic        clk;
    logic        reset_in;
    logic        enable_in;
    logic [1:0]  mode_in;
    logic [2:0]  colour_in;
    logic [23:0] top_out;
    logic [23:0] bot_out;
    logic [1:0]  row_address_out;
    logic        frame_start_out;
    logic [3:0]  pos_out;

    pattern_scan #(
        .EFFECT_TIMER (EFFECT_TIMER),
        .NUM_ROWS     (NUM_ROWS),
        .NUM_COLS     (NUM_COLS),
        .BAR_W        (BAR_W)
    ) dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .enable_in       (enable_in),
        .mode_in         (mode_in),
        .colour_in       (colour_in),
        .top_out         (top_out),
        .bot_out         (bot_out),
        .row_address_out (row_address_out),
        .frame_start_out (frame_start_out),
        .pos_out         (pos_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    typedef enum int {K_TOP, K_BOT, K_ROW, K_FRAME, K_POS} kind_e;

    typedef struct {
        int          cyc;
        int          tag;
        kind_e       kind;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mon_idx;

    int bounce_seq [14] = '{0, 1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0, 1};

    function automatic string kind_name(input kind_e k);
        case (k)
            K_TOP:   return "top_out";
            K_BOT:   return "bot_out";
            K_ROW:   return "row_address_out";
            K_FRAME: return "frame_start_out";
            default: return "pos_out";
        endcase
    endfunction

    function automatic logic [31:0] actual_of(input kind_e k);
        case (k)
            K_TOP:   return 32'(top_out);
            K_BOT:   return 32'(bot_out);
            K_ROW:   return 32'(row_address_out);
            K_FRAME: return 32'(frame_start_out);
            default: return 32'(pos_out);
        endcase
    endfunction

    task automatic check(input string name, input int tag, input int cyc,
                         input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL t%0d %s @edge %0d: got %0h, expected %0h",
                     tag, name, cyc, actual, expected);
        end
    endtask

    task automatic expect_at(input int cyc, input int tag, input kind_e kind,
                             input logic [31:0] value);
        exp_t e;
        e.cyc   = cyc;
        e.tag   = tag;
        e.kind  = kind;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic expect_row(input int cyc, input int tag, input logic [23:0] top,
                              input logic [23:0] bot, input logic [1:0] row);
        expect_at(cyc, tag, K_ROW, 32'(row));
        expect_at(cyc, tag, K_TOP, 32'(top));
        expect_at(cyc, tag, K_BOT, 32'(bot));
    endtask

    task automatic expect_all_zero(input int cyc, input int tag);
        expect_row(cyc, tag, 24'h0, 24'h0, 2'd0);
        expect_at(cyc, tag, K_FRAME, 32'd0);
        expect_at(cyc, tag, K_POS, 32'd0);
    endtask

    // Monitor: outputs are presented every cycle; compare whatever is due.
    always @(negedge clk) begin
        mon_idx = 0;
        while (mon_idx < sb.size()) begin
            if (sb[mon_idx].cyc == edges) begin
                check(kind_name(sb[mon_idx].kind), sb[mon_idx].tag, edges,
                      actual_of(sb[mon_idx].kind), sb[mon_idx].value);
                sb.delete(mon_idx);
            end else if (sb[mon_idx].cyc < edges) begin
                n_checks++;
                $display("FAIL t%0d %s @edge %0d: expectation not sampled in time",
                         sb[mon_idx].tag, kind_name(sb[mon_idx].kind), sb[mon_idx].cyc);
                sb.delete(mon_idx);
            end else begin
                mon_idx++;
            end
        end
    end

    // Leaves the caller 1 ns after rising edge n; inputs set then are
    // sampled on edge n+1.
    task automatic goto_edge(input int n);
        while (edges < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        reset_in  = 1'b1;
        enable_in = 1'b1;
        mode_in   = 2'b00;
        colour_in = 3'b001;

        // 1. Reset for edges 1..3, first live edge is 4.
        expect_all_zero(3, 1);
        expect_row(4, 1, 24'h0000FF, 24'h0, 2'd0);
        expect_at(4, 1, K_FRAME, 32'd1);
        expect_at(4, 1, K_POS, 32'd0);
        goto_edge(3);
        reset_in = 1'b0;

        // 2. Vertical bounce. Frames start at edge 4+4k; pos k applies at 4k+3.
        for (int k = 0; k < 14; k++) begin
            expect_at(4 + 4 * k + 1, 2, K_POS, 32'(bounce_seq[k]));
        end
        // Frame drawn at pos 3 (rows 3 and 4 lit).
        expect_row(16, 2, 24'h0, 24'h0000FF, 2'd0);
        expect_at(16, 2, K_FRAME, 32'd1);
        expect_row(17, 2, 24'h0, 24'h0, 2'd1);
        expect_at(17, 2, K_FRAME, 32'd0);
        expect_row(18, 2, 24'h0, 24'h0, 2'd2);
        expect_row(19, 2, 24'h0000FF, 24'h0, 2'd3);

        // 3. Horizontal wrap, axis change sampled on edge 60 (row 0).
        goto_edge(59);
        mode_in = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            expect_at(60 + 4 * k + 1, 3, K_POS, 32'((k == 8) ? 0 : k - 1));
        end
        for (int j = 0; j < 4; j++) begin
            expect_row(88 + j, 3, 24'h0000C0, 24'h0000C0, 2'(j));
        end

        // 4. Freeze at pos 2 for edges 100..119; timer is held at 3.
        goto_edge(99);
        enable_in = 1'b0;
        expect_at(101, 4, K_POS, 32'd2);
        expect_at(105, 4, K_POS, 32'd2);
        expect_at(110, 4, K_POS, 32'd2);
        expect_at(110, 4, K_ROW, 32'd2);
        expect_at(111, 4, K_ROW, 32'd3);
        expect_at(112, 4, K_ROW, 32'd0);
        expect_at(112, 4, K_FRAME, 32'd1);
        expect_at(115, 4, K_POS, 32'd2);
        expect_at(119, 4, K_POS, 32'd2);
        expect_at(122, 4, K_POS, 32'd2);
        expect_at(123, 4, K_POS, 32'd3);
        expect_at(126, 4, K_POS, 32'd3);
        expect_at(127, 4, K_POS, 32'd4);
        goto_edge(119);
        enable_in = 1'b1;

        // 5. Back to vertical bounce at edge 128, climb to pos 4, then switch
        //    to horizontal bounce on edge 148.
        goto_edge(127);
        mode_in = 2'b00;
        expect_at(143, 5, K_POS, 32'd3);
        expect_at(147, 5, K_POS, 32'd4);
        expect_at(148, 5, K_POS, 32'd0);
        for (int j = 1; j <= 4; j++) begin
            expect_row(148 + j, 5, 24'h000003, 24'h000003, 2'(j % 4));
        end
        expect_at(154, 5, K_POS, 32'd0);
        expect_at(155, 5, K_POS, 32'd1);
        goto_edge(147);
        mode_in = 2'b01;

        // 6. Reset on edges 181..182 while at pos 5 heading down.
        goto_edge(170);
        expect_at(175, 6, K_POS, 32'd6);
        expect_at(180, 6, K_POS, 32'd5);
        expect_all_zero(181, 6);
        expect_row(183, 6, 24'h000003, 24'h000003, 2'd0);
        expect_at(183, 6, K_FRAME, 32'd1);
        expect_at(183, 6, K_POS, 32'd0);
        expect_at(184, 6, K_POS, 32'd0);
        expect_at(188, 6, K_POS, 32'd1);
        expect_at(192, 6, K_POS, 32'd2);
        goto_edge(180);
        reset_in = 1'b1;
        goto_edge(182);
        reset_in = 1'b0;

        goto_edge(195);
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            n_checks++;
            $display("FAIL t%0d %s @edge %0d: expectation never sampled",
                     sb[0].tag, kind_name(sb[0].kind), sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
